m_cp0: RTL and testbench

- Coprocessor-0 for the P7 MIPS pipeline; sits in the M stage.
- Detects interrupts and exceptions, records state, and supplies the redirect signals consumed by the D-stage next-PC logic: Req forces fetch to 0x0000_4180, and EPC_out is the return target for eret.
- Implements SR(12), Cause(13), EPC(14) and PRId(15) for mfc0/mtc0.

---
 rtl/m_cp0.sv | 135 +++++++++++++
 tb/tb_m_cp0.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/m_cp0.sv
// ============================================================================
// Module   : m_cp0
// Purpose  : Coprocessor 0 for the P7 MIPS pipeline, M stage. Detects
//            interrupts and exceptions, holds SR/Cause/EPC/PRId, and drives
//            the redirect signals used by the D-stage next-PC logic.
// Ports    :
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous active-low reset
//   A1         in   5   mfc0 read register number
//   A2         in   5   mtc0 write register number
//   DIn        in  32   mtc0 write data
//   WE         in   1   mtc0 write enable
//   VPC        in  32   PC of the instruction in M
//   BDIn       in   1   M instruction sits in a branch-delay slot
//   ExcCodeIn  in   5   exception code of the M instruction (0 = none)
//   HWInt      in   6   level-sensitive external interrupt lines
//   EXLClr     in   1   eret in M, clears SR.EXL
//   Req        out  1   take exception/interrupt this cycle (combinational)
//   EPC_out    out 32   eret return address (forwards a same-cycle mtc0 EPC)
//   DOut       out 32   mfc0 read data (combinational)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module m_cp0 #(
  parameter logic [31:0] PRID = 32'h2021_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        Req,
  output logic [31:0] EPC_out,
  output logic [31:0] DOut
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // Only the implemented fields are stored; unimplemented bits read as 0.
  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic        wr_sr;
  logic        wr_epc;
  logic [31:0] vpc_aligned;
  logic [31:0] epc_capture;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // EXL blocks both sources, so no nesting while a handler is running.
  assign int_req = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = (ExcCodeIn != 5'd0) & ~sr_exl;
  assign Req     = int_req | exc_req;

  assign wr_sr  = WE & (A2 == REG_SR);
  assign wr_epc = WE & (A2 == REG_EPC);

  // A delay-slot instruction must restart at its branch, one word earlier.
  assign vpc_aligned = {VPC[31:2], 2'b00};
  assign epc_capture = BDIn ? (vpc_aligned - 32'd4) : vpc_aligned;

  assign sr_word    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
  assign cause_word = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};

  // An mtc0 EPC directly before eret must already steer the return target.
  // When Req is high the mtc0 is squashed, so no forwarding then.
  assign EPC_out = (wr_epc & ~Req) ? DIn : epc;

  always_comb begin
    DOut = 32'd0;
    case (A1)
      REG_SR:    DOut = sr_word;
      REG_CAUSE: DOut = cause_word;
      REG_EPC:   DOut = epc;
      REG_PRID:  DOut = PRID;
      default:   DOut = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im     <= 6'd0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'd0;
      cause_exc <= 5'd0;
      epc       <= 32'd0;
    end else begin
      // Pending lines are sampled every cycle, independent of EXL/Req.
      cause_ip <= HWInt;
      if (Req) begin
        // Entering the handler: the M instruction is squashed, so any
        // mtc0 or eret it carried is dropped. Interrupts report code 0.
        sr_exl    <= 1'b1;
        cause_exc <= int_req ? 5'd0 : ExcCodeIn;
        cause_bd  <= BDIn;
        epc       <= epc_capture;
      end else begin
        if (wr_sr) begin
          sr_im  <= DIn[15:10];
          sr_exl <= DIn[1];
          sr_ie  <= DIn[0];
        end
        // Placed after the SR write so eret wins the EXL bit.
        if (EXLClr) begin
          sr_exl <= 1'b0;
        end
        if (wr_epc) begin
          epc <= DIn;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_m_cp0.sv
// ============================================================================
// Module   : tb_m_cp0
// Purpose  : Self-checking bench for m_cp0. Each table row is one cycle of
//            inputs plus the combinational outputs expected in that cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_m_cp0;

  logic        clk;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        Req;
  logic [31:0] EPC_out;
  logic [31:0] DOut;

  int errors = 0;
  int checks = 0;

  m_cp0 dut (
    .clk       (clk),
    .reset     (reset),
    .A1        (A1),
    .A2        (A2),
    .DIn       (DIn),
    .WE        (WE),
    .VPC       (VPC),
    .BDIn      (BDIn),
    .ExcCodeIn (ExcCodeIn),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .Req       (Req),
    .EPC_out   (EPC_out),
    .DOut      (DOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] din;
    logic        we;
    logic [31:0] vpc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        eclr;
    logic        req;
    logic [31:0] epc;
    logic [31:0] dout;
  } vec_t;

  typedef struct {
    int          row;
    logic        req;
    logic [31:0] epc;
    logic [31:0] dout;
  } exp_t;

  vec_t vecs[36];
  exp_t sb[$];

  function automatic vec_t mk(logic rst, logic [4:0] a1, logic [4:0] a2,
                              logic [31:0] din, logic we, logic [31:0] vpc,
                              logic bd, logic [4:0] exc, logic [5:0] hw,
                              logic eclr, logic req, logic [31:0] epc,
                              logic [31:0] dout);
    vec_t v;
    v.rst = rst; v.a1 = a1; v.a2 = a2; v.din = din; v.we = we; v.vpc = vpc;
    v.bd = bd; v.exc = exc; v.hw = hw; v.eclr = eclr;
    v.req = req; v.epc = epc; v.dout = dout;
    return v;
  endfunction

  task automatic chk(input string name, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  // Drive one row, queue its expectation, compare at the falling edge.
  task automatic apply(input vec_t v, input int row);
    exp_t e;
    exp_t got;
    reset = v.rst; A1 = v.a1; A2 = v.a2; DIn = v.din; WE = v.we;
    VPC = v.vpc; BDIn = v.bd; ExcCodeIn = v.exc; HWInt = v.hw;
    EXLClr = v.eclr;
    e.row = row; e.req = v.req; e.epc = v.epc; e.dout = v.dout;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    chk("Req",     got.row, {31'd0, Req}, {31'd0, got.req});
    chk("EPC_out", got.row, EPC_out,      got.epc);
    chk("DOut",    got.row, DOut,         got.dout);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    //            rst a1  a2  din           we vpc       bd exc hw     eclr req epc           dout
    vecs[0]  = mk(0, 12, 0,  32'h0,        0, 32'h0,    0, 0,  6'd0,  0,   0, 32'h0,      32'h0);
    vecs[1]  = mk(1, 15, 0,  32'h0,        0, 32'h0,    0, 0,  6'd0,  0,   0, 32'h0,      32'h2021_0007);
    vecs[2]  = mk(1, 12, 12, 32'hFFFF_FFFF,1, 32'h0,    0, 0,  6'd0,  0,   0, 32'h0,      32'h0);
    vecs[3]  = mk(1, 12, 13, 32'hFFFF_FFFF,1, 32'h0,    0, 0,  6'd0,  0,   0, 32'h0,      32'h0000_FC03);
    vecs[4]  = mk(1, 13, 0,  32'h0,        0, 32'h0,    0, 0,  6'd0,  1,   0, 32'h0,      32'h0);
    vecs[5]  = mk(1, 12, 12, 32'h0401,     1, 32'h0,    0, 0,  6'd0,  0,   0, 32'h0,      32'h0000_FC01);
    vecs[6]  = mk(1, 12, 0,  32'h0,        0, 32'h3008, 0, 0,  6'd1,  0,   1, 32'h0,      32'h0401);
    vecs[7]  = mk(1, 13, 0,  32'h0,        0, 32'h0,    0, 0,  6'd1,  0,   0, 32'h3008,   32'h0400);
    vecs[8]  = mk(1, 12, 0,  32'h0,        0, 32'h0,    0, 0,  6'd1,  0,   0, 32'h3008,   32'h0403);
    vecs[9]  = mk(1, 14, 14, 32'h3100,     1, 32'h0,    0, 0,  6'd1,  0,   0, 32'h3100,   32'h3008);
    vecs[10] = mk(1, 14, 0,  32'h0,        0, 32'h0,    0, 0,  6'd1,  1,   0, 32'h3100,   32'h3100);
    vecs[11] = mk(1, 12, 0,  32'h0,        0, 32'h3104, 0, 0,  6'd1,  0,   1, 32'h3100,   32'h0401);
    vecs[12] = mk(1, 14, 12, 32'h0,        1, 32'h0,    0, 0,  6'd0,  1,   0, 32'h3104,   32'h3104);
    vecs[13] = mk(1, 12, 0,  32'h0,        0, 32'h3024, 1, 12, 6'd0,  0,   1, 32'h3104,   32'h0);
    vecs[14] = mk(1, 13, 0,  32'h0,        0, 32'h0,    0, 5,  6'd0,  0,   0, 32'h3020,   32'h8000_0030);
    vecs[15] = mk(1, 14, 12, 32'h0C03,     1, 32'h0,    0, 0,  6'd0,  1,   0, 32'h3020,   32'h3020);
    vecs[16] = mk(1, 12, 12, 32'h0,        1, 32'h3040, 0, 10, 6'd2,  0,   1, 32'h3020,   32'h0C01);
    vecs[17] = mk(1, 13, 0,  32'h0,        0, 32'h0,    0, 0,  6'd0,  0,   0, 32'h3040,   32'h0800);
    vecs[18] = mk(1, 12, 0,  32'h0,        0, 32'h0,    0, 0,  6'd0,  0,   0, 32'h3040,   32'h0C03);
    vecs[19] = mk(1, 14, 0,  32'h0,        0, 32'h0,    0, 0,  6'd0,  1,   0, 32'h3040,   32'h3040);
    vecs[20] = mk(1, 15, 14, 32'h7777_0000,1, 32'h3050, 0, 4,  6'd0,  0,   1, 32'h3040,   32'h2021_0007);
    vecs[21] = mk(1, 14, 0,  32'h0,        0, 32'h0,    0, 0,  6'd0,  0,   0, 32'h3050,   32'h3050);
    vecs[22] = mk(1, 13, 0,  32'h0,        0, 32'h0,    0, 0,  6'd0,  0,   0, 32'h3050,   32'h0010);
    vecs[23] = mk(1, 7,  0,  32'h0,        0, 32'h0,    0, 0,  6'd0,  0,   0, 32'h3050,   32'h0);
    vecs[24] = mk(1, 0,  12, 32'hFFFF_FFFF,1, 32'h0,    0, 0,  6'd0,  0,   0, 32'h3050,   32'h0);
    vecs[25] = mk(1, 12, 14, 32'h3010,     1, 32'h0,    0, 0,  6'd1,  0,   0, 32'h3010,   32'h0000_FC03);
    vecs[26] = mk(1, 14, 0,  32'h0,        0, 32'h0,    0, 0,  6'd1,  0,   0, 32'h3010,   32'h3010);
    vecs[27] = mk(0, 12, 0,  32'h0,        0, 32'h0,    0, 0,  6'd1,  0,   0, 32'h0,      32'h0);
    vecs[28] = mk(0, 13, 0,  32'h0,        0, 32'h0,    0, 0,  6'd1,  0,   0, 32'h0,      32'h0);
    vecs[29] = mk(0, 14, 0,  32'h0,        0, 32'h0,    0, 0,  6'd0,  0,   0, 32'h0,      32'h0);
    vecs[30] = mk(1, 15, 0,  32'h0,        0, 32'h0,    0, 0,  6'd0,  0,   0, 32'h0,      32'h2021_0007);
    vecs[31] = mk(1, 13, 0,  32'h0,        0, 32'h3027, 1, 8,  6'd0,  0,   1, 32'h0,      32'h0);
    vecs[32] = mk(1, 14, 0,  32'h0,        0, 32'h0,    0, 0,  6'd0,  0,   0, 32'h3020,   32'h3020);
    vecs[33] = mk(1, 13, 0,  32'h0,        0, 32'h0,    0, 0,  6'd0,  0,   0, 32'h3020,   32'h8000_0020);
    vecs[34] = mk(1, 12, 0,  32'h0,        0, 32'h0,    0, 0,  6'd0,  1,   0, 32'h3020,   32'h0002);
    vecs[35] = mk(1, 12, 12, 32'h0401,     1, 32'h0,    0, 0,  6'd0,  0,   0, 32'h3020,   32'h0);

    reset = 1'b0; A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; WE = 1'b0;
    VPC = 32'd0; BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 36; i++) begin
      apply(vecs[i], i);
    end

    // Req follows HWInt within the cycle; only unmasked lines count.
    // State here: SR.IM=000001, IE=1, EXL=0.
    WE = 1'b0; EXLClr = 1'b0; ExcCodeIn = 5'd0; A1 = 5'd0;
    HWInt = 6'b000000; #1;
    chk("Req_comb_idle",   100, {31'd0, Req}, 32'd0);
    HWInt = 6'b100000; #1;
    chk("Req_comb_masked", 101, {31'd0, Req}, 32'd0);
    HWInt = 6'b000001; #1;
    chk("Req_comb_hit",    102, {31'd0, Req}, 32'd1);
    HWInt = 6'b000000; #1;
    chk("Req_comb_drop",   103, {31'd0, Req}, 32'd0);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: got %0d entries left expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
